interrupt_controller: RTL and testbench

Fixed-priority, maskable interrupt controller between the device interrupt lines and the `cpu` core. It edge-detects up to `N_IRQ` device requests into a pending register and raises a single request to the CPU with a jump vector. It then tracks the in-service interrupt through an acknowledge / end-of-interrupt handshake. There is no nesting: at most one interrupt is in service at a time.

---
 rtl/interrupt_controller.sv | 110 +++++++++++
 tb/tb_interrupt_controller.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Fixed-priority, maskable interrupt controller with edge-detected pending bits and
// an ack / end-of-interrupt handshake. At most one interrupt is in service at a time.
module interrupt_controller #(
    parameter int              N_IRQ      = 3,
    parameter int              VEC_W      = 10,
    parameter logic [VEC_W-1:0] VEC_BASE  = VEC_W'(1000),
    parameter int              VEC_STRIDE = 4,
    localparam int             ID_W       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             int_ack,
    input  logic             eoi,
    output logic             int_req,
    output logic [ID_W-1:0]  int_id,
    output logic [VEC_W-1:0] int_vec,
    output logic             busy,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] mask
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t           state, state_next;
    logic [N_IRQ-1:0] irq_prev;
    logic [N_IRQ-1:0] irq_edge;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] clr;
    logic [ID_W-1:0]  win_id, id_next;
    logic [VEC_W-1:0] win_vec, vec_next;
    logic             ack_take;

    assign irq_edge = irq_in & ~irq_prev;
    assign eligible = pending & ~mask;

    // Descending scan so the lowest set index is the last (and winning) assignment.
    always_comb begin
        win_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (eligible[i]) win_id = ID_W'(i);
    end

    assign win_vec = VEC_BASE + VEC_W'(VEC_STRIDE) * VEC_W'(win_id);

    always_comb begin
        state_next = state;
        id_next    = int_id;
        vec_next   = int_vec;
        ack_take   = 1'b0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_next = REQ;
                    id_next    = win_id;
                    vec_next   = win_vec;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_next = SERVICE;
                    ack_take   = 1'b1;
                end else if (mask[int_id]) begin
                    state_next = IDLE;
                    id_next    = '0;
                    vec_next   = '0;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_next = IDLE;
                    id_next    = '0;
                    vec_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                id_next    = '0;
                vec_next   = '0;
            end
        endcase
    end

    assign clr = ack_take ? (N_IRQ'(1) << int_id) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            int_id   <= '0;
            int_vec  <= '0;
            irq_prev <= '0;
            pending  <= '0;
            mask     <= '0;
        end else begin
            state    <= state_next;
            int_id   <= id_next;
            int_vec  <= vec_next;
            irq_prev <= irq_in;
            // A new edge in the ack cycle re-arms the bit: set beats clear.
            pending  <= (pending & ~clr) | irq_edge;
            if (mask_we) mask <= mask_wdata;
        end
    end

    assign int_req = (state == REQ);
    assign busy    = (state == SERVICE);

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: request latency, priority, freeze,
// masking, boundary handshakes and asynchronous reset.
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] irq_in;
    logic       mask_we;
    logic [2:0] mask_wdata;
    logic       int_ack;
    logic       eoi;
    logic       int_req;
    logic [1:0] int_id;
    logic [9:0] int_vec;
    logic       busy;
    logic [2:0] pending;
    logic [2:0] mask;

    int checks   = 0;
    int failures = 0;

    interrupt_controller dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .eoi        (eoi),
        .int_req    (int_req),
        .int_id     (int_id),
        .int_vec    (int_vec),
        .busy       (busy),
        .pending    (pending),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
        int_ack = 1'b0; eoi = 1'b0;
        tick(); tick();
        chk("rst_req", 32'(int_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_id", 32'(int_id), 0);
        chk("rst_vec", 32'(int_vec), 0);
        chk("rst_pend", 32'(pending), 0);
        chk("rst_mask", 32'(mask), 0);
        reset = 1'b1;
        tick();

        // single request on source 0
        irq_in = 3'b001; tick(); irq_in = '0;
        chk("s_pend", 32'(pending), 3'b001);
        chk("s_req_early", 32'(int_req), 0);
        tick();
        chk("s_req", 32'(int_req), 1);
        chk("s_id", 32'(int_id), 0);
        chk("s_vec", 32'(int_vec), 1000);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("s_busy", 32'(busy), 1);
        chk("s_req_ack", 32'(int_req), 0);
        chk("s_pend_ack", 32'(pending), 0);
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk("s_busy_eoi", 32'(busy), 0);
        chk("s_vec_idle", 32'(int_vec), 0);

        // eoi in IDLE is ignored
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk("eoi_idle_busy", 32'(busy), 0);
        chk("eoi_idle_req", 32'(int_req), 0);
        chk("eoi_idle_pend", 32'(pending), 0);

        // priority: sources 2 and 1 together
        irq_in = 3'b110; tick(); irq_in = '0; tick();
        chk("p_req", 32'(int_req), 1);
        chk("p_id1", 32'(int_id), 1);
        chk("p_vec1", 32'(int_vec), 1004);
        int_ack = 1'b1; tick();
        chk("p_pend", 32'(pending), 3'b100);
        // ack in SERVICE is ignored
        tick(); int_ack = 1'b0;
        chk("ack_svc_busy", 32'(busy), 1);
        chk("ack_svc_pend", 32'(pending), 3'b100);
        chk("ack_svc_id", 32'(int_id), 1);
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk("p_idle_gap", 32'(int_req), 0);
        tick();
        chk("p_req2", 32'(int_req), 1);
        chk("p_id2", 32'(int_id), 2);
        chk("p_vec2", 32'(int_vec), 1008);

        // freeze: source 0 arrives while source 2 is requesting
        irq_in = 3'b001; tick(); irq_in = '0; tick();
        chk("f_pend", 32'(pending), 3'b101);
        chk("f_id", 32'(int_id), 2);
        chk("f_req", 32'(int_req), 1);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        chk("f_id0", 32'(int_id), 0);
        chk("f_vec0", 32'(int_vec), 1000);

        // new edge on source 0 during its ack cycle keeps it pending
        int_ack = 1'b1; irq_in = 3'b001; tick(); int_ack = 1'b0; irq_in = '0;
        chk("b_pend", 32'(pending), 3'b001);
        chk("b_busy", 32'(busy), 1);
        eoi = 1'b1; tick(); eoi = 1'b0; tick();
        chk("b_rereq", 32'(int_req), 1);
        chk("b_reid", 32'(int_id), 0);

        // mask source 0 while it is in REQ
        mask_we = 1'b1; mask_wdata = 3'b001; tick(); mask_we = 1'b0;
        chk("mr_mask", 32'(mask), 3'b001);
        chk("mr_req_hold", 32'(int_req), 1);
        tick();
        chk("mr_req", 32'(int_req), 0);
        chk("mr_pend", 32'(pending), 3'b001);
        chk("mr_vec", 32'(int_vec), 0);

        // unmask: request returns two edges after the write
        mask_we = 1'b1; mask_wdata = 3'b000; tick(); mask_we = 1'b0;
        chk("um_req_early", 32'(int_req), 0);
        tick();
        chk("um_req", 32'(int_req), 1);
        chk("um_id", 32'(int_id), 0);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;

        // masked source latches but does not request
        mask_we = 1'b1; mask_wdata = 3'b010; tick(); mask_we = 1'b0;
        irq_in = 3'b010; tick(); irq_in = '0; tick(); tick();
        chk("m_pend", 32'(pending), 3'b010);
        chk("m_req", 32'(int_req), 0);
        mask_we = 1'b1; mask_wdata = 3'b000; tick(); mask_we = 1'b0;
        chk("m_req_early", 32'(int_req), 0);
        tick();
        chk("m_req_rise", 32'(int_req), 1);
        chk("m_id", 32'(int_id), 1);
        chk("m_vec", 32'(int_vec), 1004);

        // reset during SERVICE clears everything without a clock edge
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        irq_in = 3'b100; tick(); irq_in = '0;
        chk("r_busy", 32'(busy), 1);
        chk("r_pend", 32'(pending), 3'b100);
        reset = 1'b0; #1;
        chk("r_busy0", 32'(busy), 0);
        chk("r_req0", 32'(int_req), 0);
        chk("r_id0", 32'(int_id), 0);
        chk("r_vec0", 32'(int_vec), 0);
        chk("r_pend0", 32'(pending), 0);
        chk("r_mask0", 32'(mask), 0);
        tick();
        reset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
